// File: rtl/m_memarb_pkg.sv
// Shared defines for the fetch/data memory arbiter: default widths, starvation
// limit and the priority-state encoding.
package m_memarb_pkg;
    localparam int ADDR_W_DEF     = 12;
    localparam int DATA_W_DEF     = 32;
    localparam int STARVE_MAX_DEF = 4;
    localparam int STARVE_W       = 4;

    typedef enum logic {
        PRIO_NORMAL = 1'b0,
        PRIO_FORCED = 1'b1
    } prio_e;
endpackage

// File: rtl/m_memarb_if.sv
// Requester and shared-memory bus seen by m_memarb; the arbiter uses the slave
// side, and requesters and memory use the master side.
interface m_memarb_if import m_memarb_pkg::*; #(
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int DATA_W = DATA_W_DEF
) ();
    logic              w_if_req;
    logic [ADDR_W-1:0] w_if_addr;
    logic              w_if_gnt;
    logic              r_if_rvalid;
    logic [DATA_W-1:0] w_if_rdata;
    logic              w_dm_req;
    logic              w_dm_we;
    logic [ADDR_W-1:0] w_dm_addr;
    logic [DATA_W-1:0] w_dm_wdata;
    logic              w_dm_gnt;
    logic              r_dm_rvalid;
    logic [DATA_W-1:0] w_dm_rdata;
    logic [ADDR_W-1:0] w_mem_addr;
    logic              w_mem_we;
    logic [DATA_W-1:0] w_mem_din;
    logic [DATA_W-1:0] w_mem_dout;
    logic              w_if_stall;
    logic [31:0]       r_conflicts;

    modport slave (
        input  w_if_req, w_if_addr, w_dm_req, w_dm_we, w_dm_addr, w_dm_wdata, w_mem_dout,
        output w_if_gnt, r_if_rvalid, w_if_rdata, w_dm_gnt, r_dm_rvalid, w_dm_rdata,
               w_mem_addr, w_mem_we, w_mem_din, w_if_stall, r_conflicts
    );

    modport master (
        output w_if_req, w_if_addr, w_dm_req, w_dm_we, w_dm_addr, w_dm_wdata, w_mem_dout,
        input  w_if_gnt, r_if_rvalid, w_if_rdata, w_dm_gnt, r_dm_rvalid, w_dm_rdata,
               w_mem_addr, w_mem_we, w_mem_din, w_if_stall, r_conflicts
    );
endinterface

// File: rtl/m_satcnt.sv
// Saturating up-counter with synchronous clear; clear wins over increment.
module m_satcnt import m_memarb_pkg::*; #(
    parameter int W = STARVE_W
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         inc,
    input  logic         clr,
    input  logic [W-1:0] max,
    output logic [W-1:0] count
);
    always_ff @(posedge clk or posedge rst) begin
        if (rst)                     count <= '0;
        else if (clr)                count <= '0;
        else if (inc && count < max) count <= count + 1'b1;
    end
endmodule

// File: rtl/m_memarb.sv
// Single-port memory arbiter between instruction fetch and data access.
// Data wins by default; fetch wins once it has been refused STARVE_MAX times.
module m_memarb import m_memarb_pkg::*; #(
    parameter int ADDR_W     = ADDR_W_DEF,
    parameter int DATA_W     = DATA_W_DEF,
    parameter int STARVE_MAX = STARVE_MAX_DEF
) (
    input logic     w_clk,
    input logic     w_rst,
    m_memarb_if.slave bus
);
    localparam logic [STARVE_W-1:0] SMAX = STARVE_W'(STARVE_MAX);

    prio_e               state, state_n;
    logic [STARVE_W-1:0] r_starve;
    logic [31:0]         r_conflicts;
    logic                if_gnt, dm_gnt;

    m_satcnt #(.W(STARVE_W)) u_satcnt (
        .clk   (w_clk),
        .rst   (w_rst),
        .inc   (bus.w_if_req && !if_gnt),
        .clr   (if_gnt),
        .max   (SMAX),
        .count (r_starve)
    );

    always_ff @(posedge w_clk or posedge w_rst) begin
        if (w_rst) state <= PRIO_NORMAL;
        else       state <= state_n;
    end

    // The state tracks r_starve==STARVE_MAX, so it moves to FORCED on the
    // refusal that brings the counter up to the limit.
    always_comb begin
        state_n = state;
        if_gnt  = 1'b0;
        dm_gnt  = 1'b0;
        if (!w_rst) begin
            if_gnt = bus.w_if_req && (!bus.w_dm_req || state == PRIO_FORCED);
            dm_gnt = bus.w_dm_req && !if_gnt;
        end
        if (if_gnt)
            state_n = PRIO_NORMAL;
        else if (bus.w_if_req && r_starve >= SMAX - 1'b1)
            state_n = PRIO_FORCED;
    end

    always_comb begin
        bus.w_mem_addr = '0;
        bus.w_mem_we   = 1'b0;
        bus.w_mem_din  = '0;
        if (if_gnt) begin
            bus.w_mem_addr = bus.w_if_addr;
        end else if (dm_gnt) begin
            bus.w_mem_addr = bus.w_dm_addr;
            bus.w_mem_we   = bus.w_dm_we;
            bus.w_mem_din  = bus.w_dm_wdata;
        end
    end

    always_ff @(posedge w_clk or posedge w_rst) begin
        if (w_rst) begin
            bus.r_if_rvalid <= 1'b0;
            bus.r_dm_rvalid <= 1'b0;
        end else begin
            bus.r_if_rvalid <= if_gnt;
            bus.r_dm_rvalid <= dm_gnt && !bus.w_dm_we;
        end
    end

    always_ff @(posedge w_clk or posedge w_rst) begin
        if (w_rst)                           r_conflicts <= '0;
        else if (bus.w_if_req && bus.w_dm_req) r_conflicts <= r_conflicts + 32'd1;
    end

    assign bus.w_if_gnt    = if_gnt;
    assign bus.w_dm_gnt    = dm_gnt;
    assign bus.w_if_stall  = bus.w_if_req && !if_gnt;
    assign bus.w_if_rdata  = bus.r_if_rvalid ? bus.w_mem_dout : '0;
    assign bus.w_dm_rdata  = bus.r_dm_rvalid ? bus.w_mem_dout : '0;
    assign bus.r_conflicts = r_conflicts;
endmodule

// File: doc/m_memarb.md
M_MEMARB -- requirements
Module: m_memarb

Interface
REQ-001 Parameter ADDR_W, default 12: word-address width, matching a 4K-word memory.
REQ-002 Parameter DATA_W, default 32: data width.
REQ-003 Parameter STARVE_MAX, default 4: consecutive refused fetch cycles before fetch gets forced priority; legal range 1..15.
REQ-004 Clocking and reset are decided: one clock, w_clk; reset w_rst is asynchronous and active-high.
REQ-005 Ports (name, direction, width, meaning):
- w_clk  in  1  clock, rising edge.
- w_rst  in  1  asynchronous active-high reset.
- w_if_req  in  1  instruction-fetch request.
- w_if_addr  in  ADDR_W  fetch word address.
- w_if_gnt  out  1  fetch granted this cycle.
- r_if_rvalid  out  1  fetch data valid.
- w_if_rdata  out  DATA_W  fetch read data.
- w_dm_req  in  1  data-memory request.
- w_dm_we  in  1  data request is a write.
- w_dm_addr  in  ADDR_W  data word address.
- w_dm_wdata  in  DATA_W  store data.
- w_dm_gnt  out  1  data request granted this cycle.
- r_dm_rvalid  out  1  load data valid.
- w_dm_rdata  out  DATA_W  load read data.
- w_mem_addr  out  ADDR_W  shared single-port memory address.
- w_mem_we  out  1  shared memory write enable.
- w_mem_din  out  DATA_W  shared memory write data.
- w_mem_dout  in  DATA_W  shared memory read data, 1-cycle registered latency.
- w_if_stall  out  1  equals w_if_req && !w_if_gnt.
- r_conflicts  out  32  count of cycles with both requests asserted.

Function
REQ-006 Grants SHALL be combinational in the request cycle; at most one of w_if_gnt / w_dm_gnt is high in any cycle.
REQ-007 Default priority: data over fetch. When w_if_req=1 and r_starve==STARVE_MAX, fetch SHALL win over data.
REQ-008 A lone request SHALL always be granted in the same cycle.
REQ-009 r_starve (4-bit) SHALL:
- increment when w_if_req && !w_if_gnt, saturating at STARVE_MAX;
- clear to 0 when w_if_gnt=1;
- hold otherwise.
REQ-010 Priority state machine: NORMAL (r_starve<STARVE_MAX), FORCED (r_starve==STARVE_MAX). FORCED->NORMAL on a fetch grant. NORMAL->FORCED when the counter reaches STARVE_MAX.
REQ-011 Memory drive, all combinational:
- fetch granted: w_mem_addr=w_if_addr, w_mem_we=0;
- data granted: w_mem_addr=w_dm_addr, w_mem_we=w_dm_we, w_mem_din=w_dm_wdata;
- no grant: addr=0, we=0, din=0.
REQ-012 Response valids are registered one cycle after the grant: r_if_rvalid <= w_if_gnt; r_dm_rvalid <= w_dm_gnt && !w_dm_we. Writes produce no rvalid.
REQ-013 w_if_rdata SHALL equal w_mem_dout when r_if_rvalid=1, else 0. w_dm_rdata follows the same rule under r_dm_rvalid.
REQ-014 Back-to-back grants to the same or alternating ports SHALL sustain one access per cycle with no bubble.
REQ-015 r_conflicts SHALL increment by 1 in each cycle with w_if_req && w_dm_req, wrapping from 2^32-1 to 0.
REQ-016 A request is not latched; a requester that is refused SHALL hold req/addr/data stable until granted. The block keeps no request queue.

Reset
REQ-017 While w_rst=1, independent of the clock:
- r_starve=0 (state NORMAL);
- r_if_rvalid=0, r_dm_rvalid=0, r_conflicts=0.
Grants are forced to 0 during reset, so w_mem_we=0.
REQ-018 A response in flight when reset asserts SHALL be discarded; no rvalid appears after reset deasserts.

Structure
REQ-019 STARVE_MAX default, ADDR_W/DATA_W defaults and the NORMAL/FORCED encodings SHALL live in the shared defines file used by the processor modules.
REQ-020 The saturating starvation counter SHALL be a sub-module, m_satcnt (inc/clr/max inputs, count output). All other logic is flat.

Verification
REQ-021 Directed scenarios:
- Fetch only, addresses 0,1,2 on consecutive cycles, with mem[n]=n+0x100 -> w_if_gnt=1 each cycle; r_if_rvalid on the next cycles with rdata 0x100, 0x101, 0x102.
- Both requests held continuously, STARVE_MAX=4 -> grant pattern D,D,D,D,F repeating; r_conflicts=10 after 10 cycles.
- Data write of 0xDEADBEEF to addr 5 while fetch is idle, then a data read of addr 5 -> no rvalid for the write; read rvalid a cycle after its grant with rdata 0xDEADBEEF.
- Fetch and load alternating every cycle -> one access per cycle; rvalids alternate; each rdata is routed only to its own port.
- Reset asserted asynchronously mid-cycle, one cycle after a data grant -> r_dm_rvalid falls immediately and stays 0; r_starve=0; r_conflicts=0.
- r_conflicts preloaded to 0xFFFFFFFF (force), then one conflict cycle -> r_conflicts wraps to 0.
